// File: rtl/bambu_mem_model_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : bambu_mem_model_mc_if
// Brief    : Master-side request bus, preload port and status outputs of the
//            multi-channel memory model. Channel c occupies slice c.
// Revision : 1.0 - initial release
// ============================================================================
interface bambu_mem_model_mc_if #(
  parameter int CHANNELS = 1,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 14,
  parameter int SIZE_W   = 4
);
  logic [CHANNELS-1:0]        Mout_oe_ram;
  logic [CHANNELS-1:0]        Mout_we_ram;
  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
  logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
  logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
  logic [CHANNELS-1:0]        M_DataRdy;
  logic                       load_we;
  logic [ADDR_W-1:0]          load_addr;
  logic [7:0]                 load_data;
  logic [CHANNELS-1:0]        err_conflict;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
           Mout_data_ram_size, load_we, load_addr, load_data,
    input  M_Rdata_ram, M_DataRdy, err_conflict
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
           Mout_data_ram_size, load_we, load_addr, load_data,
    output M_Rdata_ram, M_DataRdy, err_conflict
  );
endinterface
`default_nettype wire

// File: rtl/bambu_mem_model_mc.sv
`default_nettype none
// ============================================================================
// Module   : bambu_mem_model_mc
// Brief    : Multi-channel byte-addressed memory model with sized accesses,
//            per-channel read/write latency, preload port and sticky
//            oe/we conflict flags. Reset asserts asynchronously and is
//            expected to be released synchronously to clock.
// Revision : 1.0 - initial release
// ============================================================================
module bambu_mem_model_mc #(
  parameter int          CHANNELS  = 1,
  parameter int          DATA_W    = 8,
  parameter int          ADDR_W    = 14,
  parameter int          SIZE_W    = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          MEMSIZE   = 1024,
  parameter int          RD_DELAY  = 2,
  parameter int          WR_DELAY  = 1
) (
  input logic                 clock,
  input logic                 reset,
  bambu_mem_model_mc_if.slave bus
);
  localparam int          LANES     = DATA_W / 8;
  localparam int          MAX_DELAY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int          CNT_W     = $clog2(MAX_DELAY) + 1;
  localparam int          IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int          PIPE      = RD_DELAY - 1;
  localparam logic [63:0] BASE64    = 64'(BASE_ADDR);
  localparam logic [63:0] SIZE64    = 64'(MEMSIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [7:0]          mem_q [MEMSIZE];
  logic [CHANNELS-1:0] wr_go;
  logic [LANES-1:0]    lane_ok [CHANNELS];

  // Unsigned wrap makes addresses below the base fail the single compare.
  function automatic logic in_range(input logic [63:0] a);
    return (a - BASE64) < SIZE64;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [63:0] a);
    return IDX_W'(a - BASE64);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic              oe;
    logic              we;
    logic              act;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  last;
    logic [LANES-1:0]  lane_ok_l;
    logic [DATA_W-1:0] rd_now;
    logic [DATA_W-1:0] pipe_q [PIPE];
    logic              conflict_q;
    state_t            state_q;
    state_t            state_d;

    assign oe   = bus.Mout_oe_ram[c];
    assign we   = bus.Mout_we_ram[c];
    assign addr = bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
    assign size = bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W];

    // A simultaneous oe/we is serviced as a read, so oe selects the latency.
    assign act  = (oe | we) & in_range(64'(addr));
    assign last = oe ? CNT_W'(RD_DELAY - 1) : CNT_W'(WR_DELAY - 1);
    assign rdy  = reset & act & (cnt_q == last);

    assign wr_go[c]   = rdy & we & ~oe;
    assign lane_ok[c] = lane_ok_l;

    always_comb begin
      lane_ok_l = '0;
      rd_now    = '0;
      for (int k = 0; k < LANES; k++) begin
        if ((int'(size) >= (k + 1) * 8) && in_range(64'(addr) + 64'(k))) begin
          lane_ok_l[k]     = 1'b1;
          rd_now[k*8 +: 8] = mem_q[idx(64'(addr) + 64'(k))];
        end
      end
    end

    always_comb begin
      cnt_d   = '0;
      state_d = state_q;
      if (act && !rdy) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (act) state_d = rdy ? S_DONE : S_BUSY;
        end
        S_BUSY: begin
          if (!act)     state_d = S_IDLE;
          else if (rdy) state_d = S_DONE;
        end
        S_DONE: begin
          if (!act)     state_d = S_IDLE;
          else if (rdy) state_d = S_DONE;
          else          state_d = S_BUSY;
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q      <= '0;
        state_q    <= S_IDLE;
        conflict_q <= 1'b0;
        for (int i = 0; i < PIPE; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        cnt_q   <= cnt_d;
        state_q <= state_d;
        if (oe && we) begin
          conflict_q <= 1'b1;
        end
        pipe_q[0] <= rd_now;
        for (int i = 1; i < PIPE; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign bus.M_DataRdy[c]                      = rdy;
    assign bus.M_Rdata_ram[c*DATA_W +: DATA_W]   = (rdy & oe) ? pipe_q[PIPE-1] : '0;
    assign bus.err_conflict[c]                   = conflict_q;
  end

  // Later assignments win: higher channels first, preload last.
  always_ff @(posedge clock) begin
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_go[c] && lane_ok[c][k]) begin
          mem_q[idx(64'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]) + 64'(k))] <=
            bus.Mout_Wdata_ram[c*DATA_W + k*8 +: 8];
        end
      end
    end
    if (bus.load_we && in_range(64'(bus.load_addr))) begin
      mem_q[idx(64'(bus.load_addr))] <= bus.load_data;
    end
  end
endmodule
`default_nettype wire
